// File: rtl/bus_demux_pkg.sv
// bus_demux_pkg: shared widths and per-slot state type for the bus demultiplexing latch.
package bus_demux_pkg;
  localparam int NIBBLE_W = 4;
  localparam int NUM_SLOTS = 2;
  typedef enum logic {EMPTY, FULL} slot_state_e;
endpackage

// File: rtl/bus_demux_slot.sv
// bus_demux_slot: one capture slot with data register, full state machine and overrun handling.
// BUS_DEMUX_OVERRUN_EN selects drop-and-flag overruns; otherwise an overrun overwrites the slot.
module bus_demux_slot
  import bus_demux_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_i,
  input  logic                rd_i,
  input  logic [NIBBLE_W-1:0] din_i,
  output logic [NIBBLE_W-1:0] data_o,
  output logic                full_o,
  output logic                ovr_o
);
  slot_state_e state_q, state_d;
  logic [NIBBLE_W-1:0] data_q, data_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  // a simultaneous write keeps the slot full even when it is also being read
  always_comb state_d = (state_q == EMPTY) ? (wr_i ? FULL : EMPTY)
                                           : ((rd_i && !wr_i) ? EMPTY : FULL);
`ifdef BUS_DEMUX_OVERRUN_EN
  logic overrun, ovr_q;
  assign overrun = wr_i && (state_q == FULL) && !rd_i;
  assign data_d  = (wr_i && !overrun) ? din_i : data_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_q | overrun;
  assign ovr_o = ovr_q;
`else
  assign data_d = wr_i ? din_i : data_q;
  assign ovr_o  = 1'b0;
`endif
  always_comb begin
    full_o = (state_q == FULL);
    data_o = data_q;
  end
endmodule

// File: rtl/bus_demux_latch.sv
// bus_demux_latch: demultiplexes an inverted bus nibble into two read-acknowledged slots with tri-state outputs.
// Overrun behaviour is set by BUS_DEMUX_OVERRUN_EN (see bus_demux_slot).
module bus_demux_latch
  import bus_demux_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NIBBLE_W-1:0]     BUS,
  input  logic                    STB,
  input  logic                    SEL,
  input  logic                    RD0,
  input  logic                    RD1,
  input  logic                    OE0_N,
  input  logic                    OE1_N,
  output tri logic [NIBBLE_W-1:0] Q0,
  output tri logic [NIBBLE_W-1:0] Q1,
  output logic                    FULL0,
  output logic                    FULL1,
  output logic                    OVR0,
  output logic                    OVR1
);
  logic [NUM_SLOTS-1:0] wr, rd, full, ovr;
  logic [NIBBLE_W-1:0]  data [NUM_SLOTS];
  assign rd = {RD1, RD0};
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign wr[k] = STB && (SEL == 1'(k));
    bus_demux_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .wr_i  (wr[k]),
      .rd_i  (rd[k]),
      .din_i (~BUS),
      .data_o(data[k]),
      .full_o(full[k]),
      .ovr_o (ovr[k])
    );
  end
  // enables are deliberately not gated by reset so the cleared registers stay observable
  assign Q0    = OE0_N ? {NIBBLE_W{1'bz}} : data[0];
  assign Q1    = OE1_N ? {NIBBLE_W{1'bz}} : data[1];
  assign FULL0 = full[0];
  assign FULL1 = full[1];
  assign OVR0  = ovr[0];
  assign OVR1  = ovr[1];
endmodule

// File: tb/tb_bus_demux_latch.sv
// tb_bus_demux_latch: directed vector table, reset corner cases and randomized model comparison.
module tb_bus_demux_latch;
  logic       clk = 1'b0, reset = 1'b1;
  logic [3:0] bus = 4'h0;
  logic       stb = 1'b0, sel = 1'b0, rd0 = 1'b0, rd1 = 1'b0, oe0n = 1'b0, oe1n = 1'b0;
  wire  [3:0] q0_w, q1_w;
  logic       full0, full1, ovr0, ovr1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  // pull-ups make a released output read back as 4'hF
  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (q0_w[i]);
    pullup (q1_w[i]);
  end
  bus_demux_latch dut (
    .clk(clk), .reset(reset), .BUS(bus), .STB(stb), .SEL(sel),
    .RD0(rd0), .RD1(rd1), .OE0_N(oe0n), .OE1_N(oe1n),
    .Q0(q0_w), .Q1(q1_w), .FULL0(full0), .FULL1(full1), .OVR0(ovr0), .OVR1(ovr1)
  );
`ifdef BUS_DEMUX_OVERRUN_EN
  localparam logic [3:0] OQ = 4'h5;
  localparam logic       OO = 1'b1;
`else
  localparam logic [3:0] OQ = 4'hF;
  localparam logic       OO = 1'b0;
`endif
  typedef struct {
    logic [3:0]  bus;
    logic        stb, sel, rd0, rd1, oe0n, oe1n;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs [9];
  logic [3:0] m_data [2];
  logic       m_full [2];
  logic       m_ovr  [2];
  function automatic logic [13:0] pack(logic [3:0] a, logic [3:0] b, logic f0, logic f1, logic o0, logic o1);
    return {a, b, f0, f1, o0, o1};
  endfunction
  function automatic logic [13:0] got();
    return {q0_w, q1_w, full0, full1, ovr0, ovr1};
  endfunction
  function automatic logic [13:0] model_exp();
    return pack(oe0n ? 4'hF : m_data[0], oe1n ? 4'hF : m_data[1],
                m_full[0], m_full[1], m_ovr[0], m_ovr[1]);
  endfunction
  task automatic chk(input string nm, input logic [13:0] g, input logic [13:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got q0=%h q1=%h f=%b%b o=%b%b, expected q0=%h q1=%h f=%b%b o=%b%b",
               nm, g[13:10], g[9:6], g[5], g[4], g[3], g[2], e[13:10], e[9:6], e[5], e[4], e[3], e[2]);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 4'h0;
      m_full[k] = 1'b0;
      m_ovr[k]  = 1'b0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic wr, rd;
      wr = stb && (sel == k[0]);
      rd = (k == 0) ? rd0 : rd1;
      if (wr) begin
        if (m_full[k] && !rd) begin
`ifdef BUS_DEMUX_OVERRUN_EN
          m_ovr[k] = 1'b1;
`else
          m_data[k] = ~bus;
`endif
        end else begin
          m_data[k] = ~bus;
          m_full[k] = 1'b1;
        end
      end else if (rd) m_full[k] = 1'b0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else model_step();
    #1;
  endtask
  task automatic drive(input logic [3:0] b, input logic s, input logic sl, input logic r0, input logic r1,
                       input logic e0, input logic e1);
    @(negedge clk);
    bus = b; stb = s; sel = sl; rd0 = r0; rd1 = r1; oe0n = e0; oe1n = e1;
  endtask
  initial begin
    model_clear();
    vecs[0] = '{4'hA, 1, 0, 0, 0, 0, 0, pack(4'h5, 4'h0, 1, 0, 0, 0)};
    vecs[1] = '{4'hC, 1, 1, 0, 0, 0, 0, pack(4'h5, 4'h3, 1, 1, 0, 0)};
    vecs[2] = '{4'h0, 0, 0, 0, 1, 0, 0, pack(4'h5, 4'h3, 1, 0, 0, 0)};
    vecs[3] = '{4'h0, 0, 0, 0, 1, 0, 0, pack(4'h5, 4'h3, 1, 0, 0, 0)};
    vecs[4] = '{4'hF, 1, 0, 1, 0, 0, 0, pack(4'h0, 4'h3, 1, 0, 0, 0)};
    vecs[5] = '{4'hA, 1, 0, 1, 0, 0, 0, pack(4'h5, 4'h3, 1, 0, 0, 0)};
    vecs[6] = '{4'h0, 1, 0, 0, 0, 0, 0, pack(OQ,   4'h3, 1, 0, OO, 0)};
    vecs[7] = '{4'h0, 0, 0, 0, 0, 0, 1, pack(OQ,   4'hF, 1, 0, OO, 0)};
    vecs[8] = '{4'h9, 1, 1, 1, 0, 0, 0, pack(OQ,   4'h6, 0, 1, OO, 0)};
    #12;
    chk("reset_state", got(), pack(4'h0, 4'h0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].bus, vecs[i].stb, vecs[i].sel, vecs[i].rd0, vecs[i].rd1, vecs[i].oe0n, vecs[i].oe1n);
      tick();
      chk($sformatf("vec%0d", i), got(), vecs[i].exp);
    end
    drive(4'h3, 1, 0, 0, 0, 0, 0);
    tick();
    chk("fill0_before_reset", got(), pack(4'hC, 4'h6, 1, 1, OO, 0));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_clear", got(), pack(4'h0, 4'h0, 0, 0, 0, 0));
    tick();
    chk("strobe_during_reset", got(), pack(4'h0, 4'h0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("first_capture_after_reset", got(), pack(4'hC, 4'h0, 1, 0, 0, 0));
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      tick();
      chk($sformatf("rand%0d", i), got(), model_exp());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
